// File: rtl/axi_xbar_mst_mux.sv
// Merges one crossbar column onto a single AXI4+ATOP master port: prefixes AW/AR IDs with the source index,
// routes B/R back by ID MSBs; AW/AR grants are combinational, W follows AW order, all channels pass backpressure through.

package axi_xbar_mst_mux_pkg;

    localparam int unsigned SlvIdW = 4;
    localparam int unsigned MstIdW = 6;

    // ID is the first (most significant) field of every ID-carrying channel, so an index can be
    // prepended or stripped by plain concatenation / truncation of the whole channel.
    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
    } slv_aw_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
    } mst_aw_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } slv_ar_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } mst_ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [1:0]        resp;
    } slv_b_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [1:0]        resp;
    } mst_b_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } slv_r_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [31:0]       data;
        logic [1:0]        resp;
        logic              last;
    } mst_r_t;

    typedef struct packed {
        slv_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        slv_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        slv_b_t b;
        logic   b_valid;
        slv_r_t r;
        logic   r_valid;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_t aw;
        logic    aw_valid;
        w_t      w;
        logic    w_valid;
        logic    b_ready;
        mst_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        mst_b_t b;
        logic   b_valid;
        mst_r_t r;
        logic   r_valid;
    } mst_resp_t;

endpackage

module axi_xbar_mst_mux #(
    parameter int unsigned NoSlvPorts = 4,
    parameter int unsigned SlvIdWidth = 4,
    parameter int unsigned MstIdWidth = SlvIdWidth + $clog2(NoSlvPorts),
    parameter int unsigned MaxWTrans  = 8,
    parameter type slv_req_t  = axi_xbar_mst_mux_pkg::slv_req_t,
    parameter type slv_resp_t = axi_xbar_mst_mux_pkg::slv_resp_t,
    parameter type mst_req_t  = axi_xbar_mst_mux_pkg::mst_req_t,
    parameter type mst_resp_t = axi_xbar_mst_mux_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_reqs_i  [NoSlvPorts],
    output slv_resp_t slv_resps_o [NoSlvPorts],
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);

    localparam int unsigned IdxW = $clog2(NoSlvPorts);
    localparam int unsigned PtrW = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;
    localparam int unsigned CntW = $clog2(MaxWTrans + 1);

    typedef logic [IdxW-1:0] idx_t;

    function automatic idx_t rr_pick(input logic [NoSlvPorts-1:0] vld, input idx_t ptr);
        idx_t sel;
        logic hit;
        int   c;
        sel = ptr;
        hit = 1'b0;
        for (int k = 0; k < int'(NoSlvPorts); k++) begin
            c = (int'(ptr) + k) % int'(NoSlvPorts);
            if (!hit && vld[c]) begin
                sel = idx_t'(c);
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic idx_t rr_next(input idx_t i);
        return (i == idx_t'(NoSlvPorts - 1)) ? '0 : i + idx_t'(1);
    endfunction

    logic [NoSlvPorts-1:0] aw_vlds, ar_vlds;
    idx_t                  aw_ptr, ar_ptr, aw_lock_idx, ar_lock_idx, aw_gnt, ar_gnt;
    logic                  aw_lock, ar_lock, aw_vld, ar_vld, aw_hs, ar_hs;

    idx_t                  w_mem [MaxWTrans];
    logic [PtrW-1:0]       w_wptr, w_rptr;
    logic [CntW-1:0]       w_cnt;
    logic                  w_full, w_empty, w_vld, w_push, w_pop;
    idx_t                  w_head;

    idx_t                  b_idx, r_idx;
    logic                  b_hit, r_hit;

    always_comb begin
        for (int i = 0; i < int'(NoSlvPorts); i++) begin
            aw_vlds[i] = slv_reqs_i[i].aw_valid;
            ar_vlds[i] = slv_reqs_i[i].ar_valid;
        end
    end

    // A presented-but-unaccepted request holds its grant so payload stays stable.
    assign aw_gnt = aw_lock ? aw_lock_idx : rr_pick(aw_vlds, aw_ptr);
    assign ar_gnt = ar_lock ? ar_lock_idx : rr_pick(ar_vlds, ar_ptr);
    assign aw_vld = !rst_i && !w_full && aw_vlds[aw_gnt];
    assign ar_vld = !rst_i && ar_vlds[ar_gnt];
    assign aw_hs  = aw_vld && mst_resp_i.aw_ready;
    assign ar_hs  = ar_vld && mst_resp_i.ar_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_ptr      <= '0;
            aw_lock     <= 1'b0;
            aw_lock_idx <= '0;
            ar_ptr      <= '0;
            ar_lock     <= 1'b0;
            ar_lock_idx <= '0;
        end else begin
            if (aw_hs) begin
                aw_lock <= 1'b0;
                aw_ptr  <= rr_next(aw_gnt);
            end else if (aw_vld) begin
                aw_lock     <= 1'b1;
                aw_lock_idx <= aw_gnt;
            end
            if (ar_hs) begin
                ar_lock <= 1'b0;
                ar_ptr  <= rr_next(ar_gnt);
            end else if (ar_vld) begin
                ar_lock     <= 1'b1;
                ar_lock_idx <= ar_gnt;
            end
        end
    end

    // W-routing FIFO: entry written on AW handshake is only visible from the next cycle.
    assign w_full  = (w_cnt == CntW'(MaxWTrans));
    assign w_empty = (w_cnt == '0);
    assign w_head  = w_mem[w_rptr];
    assign w_vld   = !rst_i && !w_empty && slv_reqs_i[w_head].w_valid;
    assign w_push  = aw_hs;
    assign w_pop   = w_vld && mst_resp_i.w_ready && slv_reqs_i[w_head].w.last;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            w_mem[w_wptr] <= aw_gnt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_wptr <= '0;
            w_rptr <= '0;
            w_cnt  <= '0;
        end else begin
            if (w_push) begin
                w_wptr <= (w_wptr == PtrW'(MaxWTrans - 1)) ? '0 : w_wptr + PtrW'(1);
            end
            if (w_pop) begin
                w_rptr <= (w_rptr == PtrW'(MaxWTrans - 1)) ? '0 : w_rptr + PtrW'(1);
            end
            if (w_push && !w_pop) begin
                w_cnt <= w_cnt + CntW'(1);
            end else if (w_pop && !w_push) begin
                w_cnt <= w_cnt - CntW'(1);
            end
        end
    end

    assign b_idx = mst_resp_i.b.id[MstIdWidth-1:SlvIdWidth];
    assign r_idx = mst_resp_i.r.id[MstIdWidth-1:SlvIdWidth];
    assign b_hit = int'(b_idx) < int'(NoSlvPorts);
    assign r_hit = int'(r_idx) < int'(NoSlvPorts);

    always_comb begin
        mst_req_o = '0;
        for (int i = 0; i < int'(NoSlvPorts); i++) begin
            slv_resps_o[i]   = '0;
            slv_resps_o[i].b = mst_resp_i.b[$bits(slv_resps_o[i].b)-1:0];
            slv_resps_o[i].r = mst_resp_i.r[$bits(slv_resps_o[i].r)-1:0];
        end

        mst_req_o.aw       = {aw_gnt, slv_reqs_i[aw_gnt].aw};
        mst_req_o.aw_valid = aw_vld;
        mst_req_o.ar       = {ar_gnt, slv_reqs_i[ar_gnt].ar};
        mst_req_o.ar_valid = ar_vld;
        mst_req_o.w        = slv_reqs_i[w_head].w;
        mst_req_o.w_valid  = w_vld;

        if (!rst_i) begin
            slv_resps_o[aw_gnt].aw_ready = aw_hs;
            slv_resps_o[ar_gnt].ar_ready = ar_hs;
            slv_resps_o[w_head].w_ready  = !w_empty && mst_resp_i.w_ready;
            // Unroutable responses cannot originate here; sink them so the port never deadlocks.
            if (b_hit) begin
                slv_resps_o[b_idx].b_valid = mst_resp_i.b_valid;
                mst_req_o.b_ready          = slv_reqs_i[b_idx].b_ready;
            end else begin
                mst_req_o.b_ready = 1'b1;
            end
            if (r_hit) begin
                slv_resps_o[r_idx].r_valid = mst_resp_i.r_valid;
                mst_req_o.r_ready          = slv_reqs_i[r_idx].r_ready;
            end else begin
                mst_req_o.r_ready = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_xbar_mst_mux.sv
// Directed bench for axi_xbar_mst_mux with a 2-deep W FIFO; expected values are hand-computed per step.
module tb_axi_xbar_mst_mux;
    import axi_xbar_mst_mux_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    slv_req_t  slv_reqs  [4];
    slv_resp_t slv_resps [4];
    mst_req_t  mst_req;
    mst_resp_t mst_resp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_xbar_mst_mux #(
        .NoSlvPorts (4),
        .SlvIdWidth (4),
        .MaxWTrans  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_reqs_i  (slv_reqs),
        .slv_resps_o (slv_resps),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) slv_reqs[i] = '0;
        mst_resp = '0;
    endtask

    initial begin
        clr();
        // Reset: outputs gated even with live inputs
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].b_ready  = 1'b1;
        slv_reqs[1].ar_valid = 1'b1;
        mst_resp.aw_ready    = 1'b1;
        mst_resp.b_valid     = 1'b1;
        #2;
        check("rst_aw_valid", 32'(mst_req.aw_valid), 0);
        check("rst_ar_valid", 32'(mst_req.ar_valid), 0);
        check("rst_w_valid", 32'(mst_req.w_valid), 0);
        check("rst_b_ready", 32'(mst_req.b_ready), 0);
        check("rst_slv0_aw_ready", 32'(slv_resps[0].aw_ready), 0);
        check("rst_slv0_b_valid", 32'(slv_resps[0].b_valid), 0);
        tick();
        tick();
        clr();
        rst = 1'b0;

        // Round robin: all inputs request every cycle, W drains each burst immediately
        for (int i = 0; i < 4; i++) begin
            slv_reqs[i].aw.id    = 4'(i);
            slv_reqs[i].aw_valid = 1'b1;
            slv_reqs[i].w.data   = 32'(i);
            slv_reqs[i].w.last   = 1'b1;
            slv_reqs[i].w_valid  = 1'b1;
        end
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("rr_aw_id", 32'(mst_req.aw.id), 32'((k % 4) * 17));
            tick();
        end
        for (int i = 0; i < 4; i++) slv_reqs[i].aw_valid = 1'b0;
        #1;
        check("rr_w_head", 32'(mst_req.w.data), 3);
        tick();
        check("rr_w_empty", 32'(mst_req.w_valid), 0);
        clr();

        // Single AW on input 2, W one cycle later, B routed back
        slv_reqs[2].aw.id    = 4'h3;
        slv_reqs[2].aw.addr  = 32'h1000;
        slv_reqs[2].aw_valid = 1'b1;
        slv_reqs[2].w.data   = 32'hAA;
        slv_reqs[2].w.last   = 1'b1;
        slv_reqs[2].w_valid  = 1'b1;
        mst_resp.aw_ready    = 1'b1;
        mst_resp.w_ready     = 1'b1;
        #1;
        check("t1_aw_id", 32'(mst_req.aw.id), 'h23);
        check("t1_aw_addr", 32'(mst_req.aw.addr), 'h1000);
        check("t1_aw_rdy2", 32'(slv_resps[2].aw_ready), 1);
        check("t1_aw_rdy0", 32'(slv_resps[0].aw_ready), 0);
        check("t1_w_early", 32'(mst_req.w_valid), 0);
        tick();
        slv_reqs[2].aw_valid = 1'b0;
        #1;
        check("t1_w_valid", 32'(mst_req.w_valid), 1);
        check("t1_w_data", 32'(mst_req.w.data), 'hAA);
        check("t1_w_rdy2", 32'(slv_resps[2].w_ready), 1);
        tick();
        slv_reqs[2].w_valid = 1'b0;
        mst_resp.b_valid    = 1'b1;
        mst_resp.b.id       = 6'h23;
        mst_resp.b.resp     = 2'b10;
        slv_reqs[2].b_ready = 1'b1;
        slv_reqs[1].b_ready = 1'b1;
        #1;
        check("t1_b_vld2", 32'(slv_resps[2].b_valid), 1);
        check("t1_b_id2", 32'(slv_resps[2].b.id), 3);
        check("t1_b_resp2", 32'(slv_resps[2].b.resp), 2);
        check("t1_b_vld1", 32'(slv_resps[1].b_valid), 0);
        check("t1_b_rdy", 32'(mst_req.b_ready), 1);
        slv_reqs[2].b_ready = 1'b0;
        #1;
        check("t1_b_rdy_bp", 32'(mst_req.b_ready), 0);
        tick();
        clr();

        // Lock: input 1 granted (pointer at 3), held 5 cycles while input 0 also requests
        slv_reqs[1].aw.id    = 4'h7;
        slv_reqs[1].aw.addr  = 32'h2000;
        slv_reqs[1].aw.len   = 8'd1;
        slv_reqs[1].aw_valid = 1'b1;
        mst_resp.w_ready     = 1'b1;
        #1;
        check("lk_first_id", 32'(mst_req.aw.id), 'h17);
        tick();
        slv_reqs[0].aw.id    = 4'h9;
        slv_reqs[0].aw.addr  = 32'h3000;
        slv_reqs[0].aw_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("lk_id", 32'(mst_req.aw.id), 'h17);
            check("lk_addr", 32'(mst_req.aw.addr), 'h2000);
            check("lk_valid", 32'(mst_req.aw_valid), 1);
            tick();
        end
        mst_resp.aw_ready = 1'b1;
        #1;
        check("lk_rdy1", 32'(slv_resps[1].aw_ready), 1);
        check("lk_rdy0", 32'(slv_resps[0].aw_ready), 0);
        check("lk_hs_id", 32'(mst_req.aw.id), 'h17);
        tick();
        slv_reqs[1].aw_valid = 1'b0;
        #1;
        check("lk_next_id", 32'(mst_req.aw.id), 'h09);
        tick();
        slv_reqs[0].aw_valid = 1'b0;

        // FIFO full (entries 1,0): third AW from input 3 stalls until burst of input 1 ends
        slv_reqs[3].aw.id    = 4'h2;
        slv_reqs[3].aw_valid = 1'b1;
        slv_reqs[0].w.data   = 32'hB0;
        slv_reqs[0].w.last   = 1'b1;
        slv_reqs[0].w_valid  = 1'b1;
        #1;
        check("fu_aw_vld", 32'(mst_req.aw_valid), 0);
        check("fu_aw_rdy3", 32'(slv_resps[3].aw_ready), 0);
        check("fu_w_vld", 32'(mst_req.w_valid), 0);
        check("fu_w_rdy0", 32'(slv_resps[0].w_ready), 0);
        slv_reqs[1].w.data  = 32'hC1;
        slv_reqs[1].w.last  = 1'b0;
        slv_reqs[1].w_valid = 1'b1;
        #1;
        check("fu_w_data1", 32'(mst_req.w.data), 'hC1);
        check("fu_w_rdy1", 32'(slv_resps[1].w_ready), 1);
        tick();
        slv_reqs[1].w.data = 32'hC2;
        slv_reqs[1].w.last = 1'b1;
        #1;
        check("fu_aw_vld_last", 32'(mst_req.aw_valid), 0);
        tick();
        slv_reqs[1].w_valid = 1'b0;
        #1;
        check("fu_aw_vld_free", 32'(mst_req.aw_valid), 1);
        check("fu_aw_id", 32'(mst_req.aw.id), 'h32);
        check("fu_w_head0", 32'(mst_req.w.data), 'hB0);
        tick();
        slv_reqs[3].aw_valid = 1'b0;
        slv_reqs[0].w_valid  = 1'b0;
        slv_reqs[3].w.data   = 32'hD3;
        slv_reqs[3].w.last   = 1'b1;
        slv_reqs[3].w_valid  = 1'b1;
        #1;
        check("fu_w_head3", 32'(mst_req.w.data), 'hD3);
        tick();
        check("fu_w_empty", 32'(mst_req.w_valid), 0);
        clr();

        // AR from inputs 0 and 3, responses out of order with backpressure on input 3
        slv_reqs[0].ar.id    = 4'h5;
        slv_reqs[0].ar.addr  = 32'h100;
        slv_reqs[0].ar_valid = 1'b1;
        slv_reqs[3].ar.id    = 4'h5;
        slv_reqs[3].ar.addr  = 32'h300;
        slv_reqs[3].ar_valid = 1'b1;
        mst_resp.ar_ready    = 1'b1;
        #1;
        check("ar_id0", 32'(mst_req.ar.id), 'h05);
        check("ar_rdy0", 32'(slv_resps[0].ar_ready), 1);
        check("ar_rdy3", 32'(slv_resps[3].ar_ready), 0);
        tick();
        slv_reqs[0].ar_valid = 1'b0;
        #1;
        check("ar_id3", 32'(mst_req.ar.id), 'h35);
        check("ar_addr3", 32'(mst_req.ar.addr), 'h300);
        tick();
        slv_reqs[3].ar_valid = 1'b0;
        slv_reqs[0].r_ready  = 1'b1;
        slv_reqs[3].r_ready  = 1'b1;
        mst_resp.r_valid     = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mst_resp.r.id   = 6'h35;
            mst_resp.r.data = 32'h300 + 32'(b);
            mst_resp.r.last = (b == 3);
            if (b == 1) begin
                slv_reqs[3].r_ready = 1'b0;
                #1;
                check("r3_bp", 32'(mst_req.r_ready), 0);
                slv_reqs[3].r_ready = 1'b1;
            end
            #1;
            check("r3_vld", 32'(slv_resps[3].r_valid), 1);
            check("r3_data", 32'(slv_resps[3].r.data), 32'h300 + 32'(b));
            check("r3_id", 32'(slv_resps[3].r.id), 5);
            check("r3_last", 32'(slv_resps[3].r.last), (b == 3) ? 1 : 0);
            check("r3_vld0", 32'(slv_resps[0].r_valid), 0);
            check("r3_rdy", 32'(mst_req.r_ready), 1);
            tick();
        end
        for (int b = 0; b < 4; b++) begin
            mst_resp.r.id   = 6'h05;
            mst_resp.r.data = 32'h100 + 32'(b);
            mst_resp.r.last = (b == 3);
            #1;
            check("r0_vld", 32'(slv_resps[0].r_valid), 1);
            check("r0_last", 32'(slv_resps[0].r.last), (b == 3) ? 1 : 0);
            check("r0_vld3", 32'(slv_resps[3].r_valid), 0);
            tick();
        end
        clr();

        // Reset in the middle of a W burst
        slv_reqs[2].aw.id    = 4'h1;
        slv_reqs[2].aw_valid = 1'b1;
        slv_reqs[2].w.data   = 32'hE0;
        slv_reqs[2].w.last   = 1'b0;
        slv_reqs[2].w_valid  = 1'b1;
        mst_resp.aw_ready    = 1'b1;
        mst_resp.w_ready     = 1'b1;
        mst_resp.b_valid     = 1'b1;
        mst_resp.b.id        = 6'h00;
        slv_reqs[0].b_ready  = 1'b1;
        tick();
        slv_reqs[2].aw_valid = 1'b0;
        #1;
        check("rm_w_vld", 32'(mst_req.w_valid), 1);
        check("rm_b_rdy", 32'(mst_req.b_ready), 1);
        rst = 1'b1;
        #1;
        check("rm_w_vld_rst", 32'(mst_req.w_valid), 0);
        check("rm_b_rdy_rst", 32'(mst_req.b_ready), 0);
        tick();
        tick();
        rst = 1'b0;
        mst_resp.b_valid    = 1'b0;
        slv_reqs[0].b_ready = 1'b0;
        #1;
        check("rm_fifo_empty", 32'(mst_req.w_valid), 0);
        slv_reqs[2].w_valid  = 1'b0;
        slv_reqs[2].aw.id    = 4'h4;
        slv_reqs[2].aw_valid = 1'b1;
        slv_reqs[3].aw.id    = 4'h6;
        slv_reqs[3].aw_valid = 1'b1;
        #1;
        check("rm_ptr_id", 32'(mst_req.aw.id), 'h24);
        tick();
        slv_reqs[2].aw_valid = 1'b0;
        slv_reqs[3].aw_valid = 1'b0;
        slv_reqs[2].w.data   = 32'hE1;
        slv_reqs[2].w.last   = 1'b1;
        slv_reqs[2].w_valid  = 1'b1;
        #1;
        check("rm_w_vld2", 32'(mst_req.w_valid), 1);
        check("rm_w_data2", 32'(mst_req.w.data), 'hE1);
        tick();
        slv_reqs[2].w_valid = 1'b0;
        mst_resp.b_valid    = 1'b1;
        mst_resp.b.id       = 6'h24;
        slv_reqs[2].b_ready = 1'b1;
        #1;
        check("rm_b_vld2", 32'(slv_resps[2].b_valid), 1);
        check("rm_b_id2", 32'(slv_resps[2].b.id), 4);
        check("rm_b_rdy2", 32'(mst_req.b_ready), 1);
        tick();
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
